// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-pc select
// encoding and the stack-pointer width helpers.
package pc_pkg;

   typedef enum logic [2:0] {
      NPC_HOLD,
      NPC_INC,
      NPC_JUMP,
      NPC_CALL,
      NPC_RET
   } npc_sel_e;

   // sp must represent 0..depth inclusive, hence depth+1 states.
   function automatic int sp_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. The caller only asserts push/pop when legal, so no
// overflow/underflow detection lives here.
module ret_stack
   import pc_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter int STACK_DEPTH = 4,
   parameter int SP_W        = sp_width(STACK_DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] wdata,
   output logic [ADDR_W-1:0] rdata,
   output logic [SP_W-1:0]   sp,
   output logic              empty,
   output logic              full
);

   localparam int              IDX_W    = idx_width(STACK_DEPTH);
   localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);
   localparam logic [SP_W-1:0] SP_DEPTH = SP_W'(STACK_DEPTH);

   logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
   logic [SP_W-1:0]   r_sp;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [IDX_W-1:0]  w_rd_idx;

   assign w_wr_idx = IDX_W'(r_sp);
   assign w_rd_idx = IDX_W'(r_sp - SP_ONE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sp <= '0;
      end else if (push) begin
         r_sp <= r_sp + SP_ONE;
      end else if (pop) begin
         r_sp <= r_sp - SP_ONE;
      end
   end

   // NOTE: storage is deliberately left out of reset; sp alone defines
   // which entries are valid, and an unreset array maps onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[w_wr_idx] <= wdata;
      end
   end

   assign rdata = r_mem[w_rd_idx];
   assign sp    = r_sp;
   assign empty = (r_sp == '0);
   assign full  = (r_sp == SP_DEPTH);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, jump with link, call/return via an
// internal return stack, stall, and a start bubble after reset.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                ADDR_W      = 5,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
   localparam int               SP_W        = sp_width(STACK_DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              stall,
   input  logic              jump,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] target,
   input  logic              err_clr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link,
   output logic [SP_W-1:0]   sp,
   output logic              stack_empty,
   output logic              stack_full,
   output logic              stk_err
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_link;
   logic              r_started;
   logic              r_err;

   npc_sel_e          w_sel;
   logic              w_push;
   logic              w_pop;
   logic              w_err_set;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_top;
   logic              w_empty;
   logic              w_full;

   assign w_pc_inc = r_pc + ADDR_W'(1);

   // Priority: stall > ret > call > jump > increment.
   always_comb begin
      // NOTE: every output of this block gets a default before any branch so
      // no path leaves a signal unassigned and no latch is inferred.
      w_sel     = NPC_HOLD;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err_set = 1'b0;
      if (!stall) begin
         if (ret) begin
            if (w_empty) begin
               w_err_set = 1'b1;
            end else begin
               w_sel = NPC_RET;
               w_pop = 1'b1;
            end
         end else if (call) begin
            if (w_full) begin
               w_err_set = 1'b1;
            end else begin
               w_sel  = NPC_CALL;
               w_push = 1'b1;
            end
         end else if (jump) begin
            w_sel = NPC_JUMP;
         end else if (r_started) begin
            w_sel = NPC_INC;
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values (link captures the old pc, not the new one).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc      <= RESET_ADDR;
         r_link    <= '0;
         r_started <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (!stall) begin
            r_started <= 1'b1;
         end
         case (w_sel)
            NPC_INC: r_pc <= w_pc_inc;
            NPC_JUMP, NPC_CALL: begin
               r_pc   <= target;
               r_link <= r_pc;
            end
            NPC_RET: r_pc <= w_top;
            default: ;
         endcase
         if (w_err_set) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   ret_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH),
      .SP_W        (SP_W)
   ) u_stack (
      .clk   (clk),
      .rstn  (rstn),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (w_pc_inc),
      .rdata (w_top),
      .sp    (sp),
      .empty (w_empty),
      .full  (w_full)
   );

   assign pc          = r_pc;
   assign link        = r_link;
   assign stack_empty = w_empty;
   assign stack_full  = w_full;
   assign stk_err     = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: queue-based reference model compared
// every cycle, plus hand-computed expectations along the directed sequence.
module tb_pc_sequencer;

   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;
   localparam int SP_W   = 3;
   localparam int PC_MOD = 1 << ADDR_W;

   logic              clk     = 1'b0;
   logic              rstn    = 1'b0;
   logic              stall   = 1'b0;
   logic              jump    = 1'b0;
   logic              call    = 1'b0;
   logic              ret     = 1'b0;
   logic              err_clr = 1'b0;
   logic [ADDR_W-1:0] target  = '0;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] link;
   logic [SP_W-1:0]   sp;
   logic              stack_empty;
   logic              stack_full;
   logic              stk_err;

   pc_sequencer #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (DEPTH),
      .RESET_ADDR  ('0)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .stall       (stall),
      .jump        (jump),
      .call        (call),
      .ret         (ret),
      .target      (target),
      .err_clr     (err_clr),
      .pc          (pc),
      .link        (link),
      .sp          (sp),
      .stack_empty (stack_empty),
      .stack_full  (stack_full),
      .stk_err     (stk_err)
   );

   always #5 clk = ~clk;

   // Reference model
   int m_pc;
   int m_link;
   int m_stack[$];
   bit m_err;
   bit m_started;

   int n_asserts = 0;
   int n_fail    = 0;
   bit chk_en    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 0;
      m_link    = 0;
      m_err     = 1'b0;
      m_started = 1'b0;
      m_stack.delete();
   endtask

   task automatic model_update(input bit st, input bit j, input bit c, input bit r,
                               input int tgt, input bit ec);
      bit set_err;
      set_err = 1'b0;
      if (!st) begin
         if (r) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else set_err = 1'b1;
         end else if (c) begin
            if (m_stack.size() < DEPTH) begin
               m_stack.push_back((m_pc + 1) % PC_MOD);
               m_link = m_pc;
               m_pc   = tgt;
            end else begin
               set_err = 1'b1;
            end
         end else if (j) begin
            m_link = m_pc;
            m_pc   = tgt;
         end else if (m_started) begin
            m_pc = (m_pc + 1) % PC_MOD;
         end
         m_started = 1'b1;
      end
      if (set_err) m_err = 1'b1;
      else if (ec) m_err = 1'b0;
   endtask

   task automatic drive(input bit st, input bit j, input bit c, input bit r,
                        input int tgt, input bit ec);
      stall   = st;
      jump    = j;
      call    = c;
      ret     = r;
      target  = ADDR_W'(tgt);
      err_clr = ec;
   endtask

   // One clock: drive, advance model at the edge, return at the next falling edge.
   task automatic step(input bit st, input bit j, input bit c, input bit r,
                       input int tgt, input bit ec);
      drive(st, j, c, r, tgt, ec);
      @(posedge clk);
      model_update(st, j, c, r, tgt, ec);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   // Continuous compare against the model on every falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("cyc_pc",    pc,          m_pc);
            check("cyc_link",  link,        m_link);
            check("cyc_sp",    sp,          m_stack.size());
            check("cyc_empty", stack_empty, m_stack.size() == 0);
            check("cyc_full",  stack_full,  m_stack.size() == DEPTH);
            check("cyc_err",   stk_err,     m_err);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_pc",    pc, 0);
      check("rst_link",  link, 0);
      check("rst_sp",    sp, 0);
      check("rst_empty", stack_empty, 1);
      check("rst_err",   stk_err, 0);
      rstn = 1'b1;

      // 1: start bubble then increment
      idle(); check("t1_bubble", pc, 0);
      idle(); check("t1_pc1", pc, 1);
      idle(); check("t1_pc2", pc, 2);
      idle(); check("t1_pc3", pc, 3);
      check("t1_sp", sp, 0);
      check("t1_empty", stack_empty, 1);
      check("t1_err", stk_err, 0);

      // 2: jump near the top, then wrap silently
      step(0, 1, 0, 0, 30, 0); check("t2_jump", pc, 30); check("t2_link", link, 3);
      idle(); check("t2_pc31", pc, 31);
      idle(); check("t2_wrap", pc, 0);  check("t2_wrap_err", stk_err, 0);
      idle(); check("t2_pc1", pc, 1);

      // 3: nested call/return
      idle(); idle(); check("t3_pc3", pc, 3);
      step(0, 0, 1, 0, 10, 0); check("t3_call1", pc, 10); check("t3_sp1", sp, 1);
      idle(); check("t3_pc11", pc, 11);
      step(0, 0, 1, 0, 20, 0); check("t3_call2", pc, 20); check("t3_sp2", sp, 2);
      check("t3_link", link, 11);
      step(0, 0, 0, 1, 0, 0); check("t3_ret1", pc, 12); check("t3_sp3", sp, 1);
      step(0, 0, 0, 1, 0, 0); check("t3_ret2", pc, 4);  check("t3_sp4", sp, 0);
      check("t3_link_kept", link, 11);

      // 4: overflow and underflow
      step(0, 0, 1, 0, 8, 0);
      step(0, 0, 1, 0, 9, 0);
      step(0, 0, 1, 0, 10, 0);
      step(0, 0, 1, 0, 11, 0);
      check("t4_full_pc", pc, 11); check("t4_sp", sp, 4); check("t4_full", stack_full, 1);
      step(0, 0, 1, 0, 20, 0);
      check("t4_ovf_pc", pc, 11); check("t4_ovf_sp", sp, 4);
      check("t4_ovf_err", stk_err, 1); check("t4_ovf_link", link, 10);
      step(0, 0, 0, 0, 0, 1); check("t4_clr", stk_err, 0); check("t4_clr_pc", pc, 12);
      step(0, 0, 0, 1, 0, 0); check("t4_pop1", pc, 11);
      step(0, 0, 0, 1, 0, 0); check("t4_pop2", pc, 10);
      step(0, 0, 0, 1, 0, 0); check("t4_pop3", pc, 9);
      step(0, 0, 0, 1, 0, 0); check("t4_pop4", pc, 5); check("t4_empty", stack_empty, 1);
      step(0, 0, 0, 1, 0, 0); check("t4_unf_pc", pc, 5); check("t4_unf_err", stk_err, 1);
      step(0, 0, 0, 1, 0, 1); check("t4_set_wins", stk_err, 1);
      step(1, 0, 0, 0, 0, 1); check("t4_stall_clr", stk_err, 0); check("t4_stall_pc", pc, 5);

      // 5: priority
      step(0, 1, 0, 0, 4, 0); check("t5_jump", pc, 4); check("t5_jlink", link, 5);
      step(0, 0, 1, 0, 7, 0); check("t5_call", pc, 7); check("t5_sp", sp, 1);
      step(1, 1, 0, 0, 25, 0); check("t5_stall_pc", pc, 7); check("t5_stall_link", link, 4);
      step(0, 1, 1, 1, 25, 0); check("t5_ret_wins", pc, 5); check("t5_sp0", sp, 0);
      check("t5_link", link, 4);

      // 6: async reset while a call is pending
      step(0, 0, 1, 0, 10, 0);
      step(0, 0, 1, 0, 12, 0); check("t6_sp2", sp, 2);
      drive(0, 0, 1, 0, 3, 0);
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      check("t6_async_pc", pc, 0);
      check("t6_async_sp", sp, 0);
      check("t6_async_empty", stack_empty, 1);
      check("t6_async_link", link, 0);
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      idle(); check("t6_bubble", pc, 0);
      idle(); check("t6_pc1", pc, 1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
